// File: rtl/gpu_raster_pkg.sv
// Shared types and constants for the raster pipeline: coordinate width,
// default screen size, bounding-box scanner state encoding and vertex bundle.
package gpu_raster_pkg;

  localparam int COORD_W      = 16;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    coord_t v1_x;
    coord_t v1_y;
    coord_t v2_x;
    coord_t v2_y;
    coord_t v3_x;
    coord_t v3_y;
  } tri_verts_t;

endpackage

// File: rtl/min3_max3.sv
// Combinational minimum and maximum of three unsigned coordinates.
module min3_max3
  import gpu_raster_pkg::*;
(
  input  coord_t a,
  input  coord_t b,
  input  coord_t c,
  output coord_t min_o,
  output coord_t max_o
);

  coord_t ab_min;
  coord_t ab_max;

  assign ab_min = (a < b) ? a : b;
  assign ab_max = (a > b) ? a : b;
  assign min_o  = (ab_min < c) ? ab_min : c;
  assign max_o  = (ab_max > c) ? ab_max : c;

endmodule

// File: rtl/bbox_scanner.sv
// Latches a triangle, computes its screen-clamped bounding box and streams
// every pixel of the box in raster order under a valid/ready handshake.
module bbox_scanner
  import gpu_raster_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_nd,
  output logic               tri_rfd,
  input  logic [COORD_W-1:0] v1_x,
  input  logic [COORD_W-1:0] v1_y,
  input  logic [COORD_W-1:0] v2_x,
  input  logic [COORD_W-1:0] v2_y,
  input  logic [COORD_W-1:0] v3_x,
  input  logic [COORD_W-1:0] v3_y,
  output logic [COORD_W-1:0] o_v1_x,
  output logic [COORD_W-1:0] o_v1_y,
  output logic [COORD_W-1:0] o_v2_x,
  output logic [COORD_W-1:0] o_v2_y,
  output logic [COORD_W-1:0] o_v3_x,
  output logic [COORD_W-1:0] o_v3_y,
  output logic               nd,
  output logic [COORD_W-1:0] p_x,
  output logic [COORD_W-1:0] p_y,
  input  logic               ds_rfd,
  output logic               tri_done
);

  localparam coord_t X_LIMIT = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LIMIT = coord_t'(SCREEN_H - 1);

  scan_state_e state_q, state_d;
  tri_verts_t  verts_q, verts_d;
  coord_t      xmin_q, xmin_d, xmax_q, xmax_d;
  coord_t      ymin_q, ymin_d, ymax_q, ymax_d;
  coord_t      px_q, px_d, py_q, py_d;
  logic        nd_q, nd_d;
  logic        done_q, done_d;
  logic        rfd_q, rfd_d;

  coord_t xmin_c, xmax_c, ymin_c, ymax_c;
  coord_t xmax_cl, ymax_cl;
  logic   box_empty;

  min3_max3 u_x_range (
    .a     (verts_q.v1_x),
    .b     (verts_q.v2_x),
    .c     (verts_q.v3_x),
    .min_o (xmin_c),
    .max_o (xmax_c)
  );

  min3_max3 u_y_range (
    .a     (verts_q.v1_y),
    .b     (verts_q.v2_y),
    .c     (verts_q.v3_y),
    .min_o (ymin_c),
    .max_o (ymax_c)
  );

  // Only the max edge is clamped; a fully off-screen box then shows up as min > max.
  assign xmax_cl   = (xmax_c > X_LIMIT) ? X_LIMIT : xmax_c;
  assign ymax_cl   = (ymax_c > Y_LIMIT) ? Y_LIMIT : ymax_c;
  assign box_empty = (xmin_c > xmax_cl) || (ymin_c > ymax_cl);

  always_comb begin
    state_d = state_q;
    verts_d = verts_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    px_d    = px_q;
    py_d    = py_q;
    nd_d    = nd_q;
    done_d  = 1'b0;
    rfd_d   = rfd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tri_nd && rfd_q) begin
          verts_d = '{v1_x, v1_y, v2_x, v2_y, v3_x, v3_y};
          rfd_d   = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        xmin_d = xmin_c;
        xmax_d = xmax_cl;
        ymin_d = ymin_c;
        ymax_d = ymax_cl;
        if (box_empty) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          px_d    = xmin_c;
          py_d    = ymin_c;
          nd_d    = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (nd_q && ds_rfd) begin
          if (px_q != xmax_q) begin
            px_d = px_q + 16'd1;
          end else if (py_q != ymax_q) begin
            px_d = xmin_q;
            py_d = py_q + 16'd1;
          end else begin
            nd_d    = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        rfd_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        rfd_d   = 1'b1;
        nd_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      verts_q <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      nd_q    <= 1'b0;
      done_q  <= 1'b0;
      rfd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      verts_q <= verts_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      px_q    <= px_d;
      py_q    <= py_d;
      nd_q    <= nd_d;
      done_q  <= done_d;
      rfd_q   <= rfd_d;
    end
  end

  assign tri_rfd  = rfd_q;
  assign nd       = nd_q;
  assign p_x      = px_q;
  assign p_y      = py_q;
  assign tri_done = done_q;
  assign o_v1_x   = verts_q.v1_x;
  assign o_v1_y   = verts_q.v1_y;
  assign o_v2_x   = verts_q.v2_x;
  assign o_v2_y   = verts_q.v2_y;
  assign o_v3_x   = verts_q.v3_x;
  assign o_v3_y   = verts_q.v3_y;

endmodule

// File: tb/tb_bbox_scanner.sv
// Scoreboard bench for bbox_scanner: directed triangles push expected pixels,
// a negedge monitor pops and compares each transferred pixel.
module tb_bbox_scanner;

  logic        clk;
  logic        rst;
  logic        tri_nd;
  logic        tri_rfd;
  logic [15:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
  logic [15:0] o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y;
  logic        nd;
  logic [15:0] p_x, p_y;
  logic        ds_rfd;
  logic        tri_done;

  bbox_scanner #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk      (clk),
    .rst      (rst),
    .tri_nd   (tri_nd),
    .tri_rfd  (tri_rfd),
    .v1_x     (v1_x),
    .v1_y     (v1_y),
    .v2_x     (v2_x),
    .v2_y     (v2_y),
    .v3_x     (v3_x),
    .v3_y     (v3_y),
    .o_v1_x   (o_v1_x),
    .o_v1_y   (o_v1_y),
    .o_v2_x   (o_v2_x),
    .o_v2_y   (o_v2_y),
    .o_v3_x   (o_v3_x),
    .o_v3_y   (o_v3_y),
    .nd       (nd),
    .p_x      (p_x),
    .p_y      (p_y),
    .ds_rfd   (ds_rfd),
    .tri_done (tri_done)
  );

  typedef struct {
    int x;
    int y;
  } pix_t;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  // monitor-visible bookkeeping
  bit   first_pending = 0;
  int   exp_first_cyc = 0;
  bit   done_pending = 0;
  int   exp_done_cyc = 0;
  int   scan_cycles = 0;
  int   done_count = 0;
  int   xfer_count = 0;
  int   last_px = -1;
  int   last_py = -1;
  bit   toggle_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_box(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        pix_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
      end
  endtask

  // ds_rfd driver: in toggle mode it is 1 on the first SCAN cycle, then alternates.
  initial begin
    bit prev_nd = 0;
    ds_rfd = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode && nd && prev_nd) ds_rfd = ~ds_rfd;
      else ds_rfd = 1'b1;
      prev_nd = nd;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit prev_hold = 0;
    bit prev_done = 0;
    int prev_px = 0;
    int prev_py = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hold = 0;
        prev_done = 0;
      end else begin
        if (nd) begin
          if (first_pending) begin
            check("first_nd_latency", cyc, exp_first_cyc);
            first_pending = 0;
          end
          scan_cycles++;
          if (prev_hold) begin
            check("hold_p_x", p_x, prev_px);
            check("hold_p_y", p_y, prev_py);
          end
          if (ds_rfd) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_pixel: got (%0d,%0d), expected none", p_x, p_y);
            end else begin
              pix_t e;
              e = exp_q.pop_front();
              check("pixel_x", p_x, e.x);
              check("pixel_y", p_y, e.y);
            end
            $display("pixel (%0d,%0d) at cycle %0d", p_x, p_y, cyc);
            xfer_count++;
            last_px = p_x;
            last_py = p_y;
          end
          prev_hold = !ds_rfd;
          prev_px = p_x;
          prev_py = p_y;
        end else begin
          prev_hold = 0;
        end
        if (tri_done) begin
          check("tri_done_width", prev_done, 0);
          check("queue_empty_at_done", exp_q.size(), 0);
          if (done_pending) begin
            check("empty_box_done_latency", cyc, exp_done_cyc);
            done_pending = 0;
          end
          done_count++;
        end
        prev_done = tri_done;
      end
    end
  end

  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input bit empty_box);
    int acc;
    @(negedge clk);
    v1_x = 16'(ax); v1_y = 16'(ay);
    v2_x = 16'(bx); v2_y = 16'(by);
    v3_x = 16'(cx); v3_y = 16'(cy);
    tri_nd = 1'b1;
    check("tri_rfd_idle", tri_rfd, 1);
    @(posedge clk);
    #1;
    tri_nd = 1'b0;
    acc = cyc;
    if (empty_box) begin
      done_pending = 1;
      exp_done_cyc = acc + 1;
    end else begin
      first_pending = 1;
      exp_first_cyc = acc + 1;
    end
    check("tri_rfd_busy", tri_rfd, 0);
    check("o_v1_x", o_v1_x, ax);
    check("o_v2_y", o_v2_y, by);
    check("o_v3_x", o_v3_x, cx);
  endtask

  task automatic wait_done(input int base_done, input int bound);
    for (int i = 0; i < bound && done_count == base_done; i++) @(posedge clk);
    check("tri_done_seen", done_count, base_done + 1);
    @(negedge clk);
    check("tri_rfd_after_done", tri_rfd, 1);
  endtask

  task automatic run_tri(input string name, input int ax, input int ay, input int bx,
                         input int by, input int cx, input int cy, input bit empty_box,
                         input int exp_xfers, input int exp_scan);
    int base_done, base_xfer;
    base_done = done_count;
    base_xfer = xfer_count;
    scan_cycles = 0;
    send_tri(ax, ay, bx, by, cx, cy, empty_box);
    wait_done(base_done, 400);
    check({name, "_pixels"}, xfer_count - base_xfer, exp_xfers);
    check({name, "_scan_cycles"}, scan_cycles, exp_scan);
    $display("triangle %s: %0d pixels, %0d scan cycles", name, xfer_count - base_xfer, scan_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_done, base_xfer;
    rst = 1'b0;
    tri_nd = 1'b0;
    {v1_x, v1_y, v2_x, v2_y, v3_x, v3_y} = '0;
    repeat (3) @(negedge clk);
    check("reset_tri_rfd", tri_rfd, 1);
    check("reset_nd", nd, 0);
    check("reset_tri_done", tri_done, 0);
    check("reset_p_x", p_x, 0);
    check("reset_p_y", p_y, 0);
    check("reset_o_v1_x", o_v1_x, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Small triangle, back-to-back transfers.
    push_box(2, 4, 1, 3);
    run_tri("basic", 2, 1, 4, 1, 3, 3, 0, 9, 9);

    // Same triangle with ds_rfd alternating.
    toggle_mode = 1;
    push_box(2, 4, 1, 3);
    run_tri("toggle", 2, 1, 4, 1, 3, 3, 0, 9, 17);
    toggle_mode = 0;

    // Entirely right of the screen.
    run_tri("offscreen", 700, 10, 800, 20, 650, 30, 1, 0, 0);

    // Clipped at the bottom-right corner.
    push_box(630, 639, 470, 479);
    run_tri("clamp", 630, 470, 700, 470, 630, 500, 0, 100, 100);
    check("clamp_last_x", last_px, 639);
    check("clamp_last_y", last_py, 479);

    // Degenerate point triangle.
    push_box(5, 5, 5, 5);
    run_tri("point", 5, 5, 5, 5, 5, 5, 0, 1, 1);
    check("point_last_x", last_px, 5);

    // A second triangle offered mid-scan must be ignored.
    toggle_mode = 1;
    push_box(2, 4, 1, 3);
    base_done = done_count;
    base_xfer = xfer_count;
    send_tri(2, 1, 4, 1, 3, 3, 0);
    @(negedge clk);
    v1_x = 16'd100; v1_y = 16'd100; v2_x = 16'd101; v2_y = 16'd100; v3_x = 16'd100; v3_y = 16'd101;
    tri_nd = 1'b1;
    repeat (3) @(negedge clk);
    tri_nd = 1'b0;
    check("busy_o_v1_x", o_v1_x, 2);
    check("busy_o_v3_y", o_v3_y, 3);
    wait_done(base_done, 400);
    check("busy_pixels", xfer_count - base_xfer, 9);
    toggle_mode = 0;
    $display("triangle busy: %0d pixels", xfer_count - base_xfer);

    // Reset in the middle of a scan.
    push_box(2, 4, 1, 3);
    base_done = done_count;
    base_xfer = xfer_count;
    send_tri(2, 1, 4, 1, 3, 3, 0);
    for (int i = 0; i < 50 && xfer_count < base_xfer + 4; i++) @(negedge clk);
    check("pre_reset_pixels", xfer_count - base_xfer, 4);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_nd", nd, 0);
    check("async_reset_tri_rfd", tri_rfd, 1);
    check("async_reset_p_x", p_x, 0);
    check("async_reset_o_v1_x", o_v1_x, 0);
    exp_q.delete();
    first_pending = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_pixels", xfer_count - base_xfer, 4);
    check("post_reset_done", done_count, base_done);
    check("post_reset_nd", nd, 0);
    check("post_reset_tri_rfd", tri_rfd, 1);
    $display("triangle reset: %0d pixels before abort", xfer_count - base_xfer);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bbox_scanner.md
BBOX_SCANNER -- requirements
Module: bbox_scanner

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 640, which is the screen width in pixels.
REQ-002 The block SHALL have parameter SCREEN_H, default 480, which is the screen height in pixels.
REQ-003 Port clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port tri_nd  input  1  SHALL mean a new triangle is present on v*_x/v*_y.
REQ-006 Port tri_rfd  output  1  SHALL mean the scanner is ready to accept a triangle.
REQ-007 Ports v1_x, v1_y, v2_x, v2_y, v3_x, v3_y  input  16 each  SHALL carry unsigned vertex coordinates.
REQ-008 Ports o_v1_x … o_v3_y  output  16 each  SHALL carry the latched vertices to the barycentric stage.
REQ-009 Port nd  output  1  SHALL mean a valid pixel is on p_x/p_y.
REQ-010 Ports p_x, p_y  output  16 each  SHALL carry the current pixel coordinate.
REQ-011 Port ds_rfd  input  1  SHALL mean the downstream stage (its us_rfd) accepts a pixel.
REQ-012 Port tri_done  output  1  SHALL be a one-cycle pulse marking the end of a triangle's scan.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SETUP, SCAN and DONE.
REQ-014 In IDLE, tri_rfd SHALL be 1; in every other state it SHALL be 0.
REQ-015 A triangle SHALL be accepted when tri_nd=1 and tri_rfd=1 on the same edge; the vertices SHALL be latched and the FSM SHALL move to SETUP.
REQ-016 SETUP SHALL last one cycle and SHALL compute xmin/xmax/ymin/ymax as the min/max of the three latched vertices.
REQ-017 In SETUP, xmax SHALL be clamped to SCREEN_W-1 and ymax to SCREEN_H-1.
REQ-018 If, after clamping, xmin>xmax or ymin>ymax, the box SHALL be empty and the FSM SHALL go SETUP->DONE without asserting nd.
REQ-019 Otherwise the FSM SHALL go SETUP->SCAN with p_x=xmin, p_y=ymin and nd=1, so the first nd appears 2 cycles after acceptance.
REQ-020 A pixel transfer SHALL occur on an edge where nd=1 and ds_rfd=1.
REQ-021 While nd=1 and ds_rfd=0, p_x, p_y and nd SHALL hold unchanged.
REQ-022 Scan order SHALL be raster: on transfer, if p_x<xmax then p_x++; else p_x=xmin and p_y++.
REQ-023 A transfer at (xmax,ymax) SHALL drop nd to 0 and move the FSM to DONE on the same edge.
REQ-024 With ds_rfd held at 1, pixels SHALL transfer back-to-back at one per cycle with no bubble at row wrap.
REQ-025 In DONE, tri_done=1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-026 tri_done SHALL be 0 in all other states.
REQ-027 o_v* SHALL hold the latched vertices from acceptance until the next acceptance.
REQ-028 A degenerate triangle whose three vertices are equal and on-screen SHALL emit exactly one pixel.
REQ-029 Coordinate arithmetic SHALL be 16-bit unsigned; the increments SHALL never wrap because p_x≤xmax≤SCREEN_W-1.
REQ-030 tri_nd asserted outside IDLE SHALL be ignored.

Reset
REQ-031 On rst=0, the FSM SHALL enter IDLE immediately, regardless of clk.
REQ-032 On reset, nd=0, tri_done=0, tri_rfd=1, and p_x=p_y=0.
REQ-033 On reset, o_v* and the box registers SHALL be set to 0.
REQ-034 A reset asserted mid-SCAN SHALL abandon the triangle; after release, no pixel of it SHALL be emitted.

Structure
REQ-035 The coordinate width (16), the FSM state encoding and the default screen size SHALL live in the shared package gpu_raster_pkg.
REQ-036 The min/max computation SHALL be a sub-module min3_max3, instantiated twice (once for x, once for y).

Verification
REQ-037 Triangle (2,1),(4,1),(3,3) with ds_rfd=1 -> 9 pixels (2..4)x(1..3) in raster order, first nd 2 cycles after accept, then one tri_done.
REQ-038 Same triangle with ds_rfd toggling 1,0,1,0 -> p_x/p_y are held during each 0 cycle, the 9 pixels are still unique and ordered, and there are 17 SCAN cycles.
REQ-039 Triangle (700,10),(800,20),(650,30) with SCREEN_W=640 -> no nd pulse, tri_done 2 cycles after accept.
REQ-040 Triangle (630,470),(700,470),(630,500) -> box clamped to 630..639 x 470..479, 100 pixels, last pixel (639,479).
REQ-041 Vertices all (5,5) -> a single pixel (5,5), then tri_done.
REQ-042 rst pulsed low during SCAN of the REQ-037 triangle at pixel 4 -> nd drops asynchronously, tri_rfd=1, and no further pixels appear after release.
